// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: display data in, segment/anode pins and frame pulse out.
interface seg_scan_mux_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] digit_data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   digit_en;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;
  modport master (output digit_data, dp, digit_en, load, input seg, an, frame_done);
  modport slave  (input digit_data, dp, digit_en, load, output seg, an, frame_done);
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment driver with blanking and double-buffered frames.
module seg_scan_mux #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int BLANK_CYCLES   = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  seg_scan_mux_if.slave  bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

  typedef enum logic {BLANK, ON} phase_e;

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] data_p_q, data_a_q;
  logic [DIGITS-1:0]   dp_p_q, dp_a_q, en_p_q, en_a_q;
  logic                dirty_q;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q;
  logic                cnt_last, frame_edge;
  phase_e              ph;

  always_comb begin
    cnt_last   = cnt_q == CW'(DIV - 1);
    frame_edge = cnt_last && idx_q == IW'(DIGITS - 1);
    cnt_d      = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d      = frame_edge ? '0 : cnt_last ? idx_q + 1'b1 : idx_q;
    ph         = int'(cnt_q) < BLANK_CYCLES ? BLANK : ON;
    seg_d      = ph == ON ? {dp_a_q[idx_q], dec(data_a_q[{idx_q, 2'b00} +: 4])} : 8'h00;
    an_d       = (ph == ON && en_a_q[idx_q]) ? DIGITS'(1) << idx_q : '0;
  end

  // Outputs are built from the current scan position, so they trail cnt/idx by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      data_p_q <= '0;
      dp_p_q   <= '0;
      en_p_q   <= '0;
      data_a_q <= '0;
      dp_a_q   <= '0;
      en_a_q   <= '0;
      dirty_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d ^ SEG_OFF;
      an_q  <= an_d ^ AN_OFF;
      fd_q  <= frame_edge;
      if (bus.load) begin
        data_p_q <= bus.digit_data;
        dp_p_q   <= bus.dp;
        en_p_q   <= bus.digit_en;
      end
      dirty_q <= frame_edge ? 1'b0 : (dirty_q | bus.load);
      // A load on the frame-start edge bypasses pending and is shown this frame.
      if (frame_edge && bus.load) begin
        data_a_q <= bus.digit_data;
        dp_a_q   <= bus.dp;
        en_a_q   <= bus.digit_en;
      end else if (frame_edge && dirty_q) begin
        data_a_q <= data_p_q;
        dp_a_q   <= dp_p_q;
        en_a_q   <= en_p_q;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: random and directed scans checked against a frame-level display model.
module tb_seg_scan_mux;
  localparam int D = 4, DIV = 8, BLANK = 2, P = D * DIV;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0, nbad = 0, n = 0;

  seg_scan_mux_if #(.DIGITS(D)) b1 ();
  seg_scan_mux_if #(.DIGITS(1)) b2 ();

  seg_scan_mux #(.DIGITS(D), .DIV(DIV), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(b1));
  seg_scan_mux #(.DIGITS(1), .DIV(2), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  always #5 clk = ~clk;

  // Model: what each digit shows this frame, plus the latest load waiting for the next frame.
  logic [15:0] m_data, p_data;
  logic [3:0]  m_dp, m_en, p_dp, p_en;
  logic        dirty;
  logic [3:0]  m2_data, p2_data;
  logic        m2_dp, m2_en, p2_dp, p2_en, dirty2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s at out-cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    {m_data, m_dp, m_en, p_data, p_dp, p_en, dirty} = '0;
    {m2_data, m2_dp, m2_en, p2_data, p2_dp, p2_en, dirty2} = '0;
    n = 0;
  endtask

  task automatic step();
    int pos = n % P;
    int sl = pos / DIV;
    int c = pos % DIV;
    logic [3:0] e_an;
    logic [7:0] e_seg, e2_seg;
    logic e_fd, e2_an, e2_fd;
    e_an   = (c >= BLANK && m_en[sl]) ? ~(4'b1 << sl) : 4'hF;
    e_seg  = c >= BLANK ? ~{m_dp[sl], DEC[m_data[sl*4 +: 4]]} : 8'hFF;
    e_fd   = pos == P - 1;
    e2_seg = {m2_dp, DEC[m2_data]};
    e2_an  = m2_en;
    e2_fd  = n % 2 == 1;
    if (pos == P - 1) begin
      if (b1.load) {m_data, m_dp, m_en} = {b1.digit_data, b1.dp, b1.digit_en};
      else if (dirty) {m_data, m_dp, m_en} = {p_data, p_dp, p_en};
      dirty = 1'b0;
    end else if (b1.load) begin
      {p_data, p_dp, p_en} = {b1.digit_data, b1.dp, b1.digit_en};
      dirty = 1'b1;
    end
    if (n % 2 == 1) begin
      if (b2.load) {m2_data, m2_dp, m2_en} = {b2.digit_data, b2.dp, b2.digit_en};
      else if (dirty2) {m2_data, m2_dp, m2_en} = {p2_data, p2_dp, p2_en};
      dirty2 = 1'b0;
    end else if (b2.load) begin
      {p2_data, p2_dp, p2_en} = {b2.digit_data, b2.dp, b2.digit_en};
      dirty2 = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("an", b1.an, e_an);
    chk("seg", b1.seg, e_seg);
    chk("frame_done", b1.frame_done, e_fd);
    chk("an2", b2.an, e2_an);
    chk("seg2", b2.seg, e2_seg);
    chk("frame_done2", b2.frame_done, e2_fd);
    n++;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic load1(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    b1.digit_data = d;
    b1.dp = p;
    b1.digit_en = e;
    b1.load = 1'b1;
    step();
    b1.load = 1'b0;
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < 2 * P && n % P != pos; i++) step();
  endtask

  initial begin
    b1.digit_data = '0; b1.dp = '0; b1.digit_en = '0; b1.load = 1'b0;
    b2.digit_data = '0; b2.dp = '0; b2.digit_en = '0; b2.load = 1'b0;
    model_reset();
    #23;
    chk("rst_an", b1.an, 4'hF);
    chk("rst_seg", b1.seg, 8'hFF);
    chk("rst_fd", b1.frame_done, 1'b0);
    chk("rst_an2", b2.an, 1'b0);
    chk("rst_seg2", b2.seg, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b2.digit_data = 4'h8; b2.digit_en = 1'b1; b2.load = 1'b1;
    step();
    b2.load = 1'b0;
    run(P + 3);
    load1(16'h3210, 4'h0, 4'hF);
    run(2 * P);
    run_to(5);
    load1(16'hFFFF, 4'h0, 4'hF);
    run(P);
    run_to(P - 1);
    load1(16'h4567, 4'h0, 4'hF);
    run(P);
    load1(16'h89AB, 4'b0100, 4'b0101);
    run(2 * P);
    for (int i = 0; i < 400; i++) begin
      b1.load = $urandom_range(0, 7) == 0;
      b1.digit_data = 16'($urandom);
      b1.dp = 4'($urandom);
      b1.digit_en = 4'($urandom);
      b2.load = $urandom_range(0, 1) == 1;
      b2.digit_data = 4'($urandom);
      b2.dp = 1'($urandom);
      b2.digit_en = 1'($urandom);
      step();
    end
    b1.load = 1'b0;
    b2.load = 1'b0;
    load1(16'hDCBA, 4'hF, 4'hF);
    run(P);
    run_to(2 * DIV + 2);
    load1(16'hAAAA, 4'hF, 4'hF);
    run_to(2 * DIV + 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", b1.an, 4'hF);
    chk("mid_rst_seg", b1.seg, 8'hFF);
    chk("mid_rst_fd", b1.frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(2 * P + 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
